// File: rtl/cfgsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cfgsr_pkg
//  Purpose  : Shared types and width helpers for the config shift-register
//             chain sequencer (FSM state encoding, counter widths, parameter
//             legality check).
//  Revision : 1.0  initial release
// ============================================================================
package cfgsr_pkg;

  // Sequencer states, explicitly 3 bits wide with fixed encodings.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_SETUP      = 3'd2,
    ST_HIGH       = 3'd3,
    ST_LATCH_WAIT = 3'd4,
    ST_LATCH_HI   = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  // clog2 that never returns 0, so a counter always has at least one bit.
  function automatic int unsigned f_clog2_min1(input int unsigned v);
    if (v <= 1) return 1;
    return $clog2(v);
  endfunction

  // Bit-within-word counter width (BITCNT_W).
  function automatic int unsigned f_bitcnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

  // Word-within-chain counter width (WORDCNT_W).
  function automatic int unsigned f_wordcnt_w(input int unsigned n, input int unsigned w);
    return f_clog2_min1(n / w);
  endfunction

  // Phase divider counter width (DIVCNT_W).
  function automatic int unsigned f_divcnt_w(input int unsigned div);
    return f_clog2_min1(div);
  endfunction

  // Legal configuration: whole number of words, at least 2-bit words, DIV >= 1.
  function automatic bit f_params_ok(input int unsigned n, input int unsigned w,
                                     input int unsigned div);
    return (w >= 2) && (n >= w) && ((n % w) == 0) && (div >= 1);
  endfunction

endpackage : cfgsr_pkg
`default_nettype wire

// File: rtl/cfgsr_clkgen.sv
`default_nettype none
// ============================================================================
//  Module   : cfgsr_clkgen
//  Purpose  : Phase timer. While i_run is high it counts DIV clk cycles per
//             phase and strobes o_phase_end on the last cycle of each phase.
//  Revision : 1.0  initial release
// ============================================================================
module cfgsr_clkgen
  import cfgsr_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_phase_end
);

  localparam int unsigned C_DIVCNT_W = f_divcnt_w(DIV);

  logic [C_DIVCNT_W-1:0] r_cnt;
  logic                  w_last;

  assign w_last      = (r_cnt == C_DIVCNT_W'(DIV - 1));
  assign o_phase_end = i_run & w_last;

  // Count cycles inside a timed phase; restart at every phase boundary and
  // hold at zero while untimed so the next phase always starts fresh.
  always_ff @(posedge clk) begin
    if (rst || !i_run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_DIVCNT_W'(1);
    end
  end

endmodule : cfgsr_clkgen
`default_nettype wire

// File: rtl/cfgsr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cfgsr_ctrl
//  Purpose  : Programs an N-bit serial config chain from a W-bit host word
//             stream, generating sclk/sdi/latch/rst_n and returning the old
//             chain contents word by word. All outputs are registered and
//             aligned with the FSM state they belong to.
//  Revision : 1.0  initial release
// ============================================================================
module cfgsr_ctrl
  import cfgsr_pkg::*;
#(
  parameter int unsigned N   = 256,
  parameter int unsigned W   = 32,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_clear,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_rd_valid,
  output logic [W-1:0] o_rd_data,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_cfg_sclk,
  output logic         o_cfg_sdi,
  output logic         o_cfg_latch,
  output logic         o_cfg_rst_n,
  input  logic         i_cfg_sdo
);

  localparam int unsigned C_NW        = N / W;
  localparam int unsigned C_BITCNT_W  = f_bitcnt_w(W);
  localparam int unsigned C_WORDCNT_W = f_wordcnt_w(N, W);

  if (!f_params_ok(N, W, DIV)) begin : g_param_check
    $error("cfgsr_ctrl: N must be a non-zero multiple of W, W >= 2, DIV >= 1");
  end

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_run;
  logic                     w_phase_end;
  logic [W-1:0]             r_tx;
  logic [W-1:0]             r_rx;
  logic [C_BITCNT_W-1:0]    r_bitcnt;
  logic [C_WORDCNT_W-1:0]   r_wordcnt;
  logic                     r_clr;
  logic                     w_hs;
  logic                     w_setup_end;
  logic                     w_high_end;
  logic                     w_bit_last;
  logic                     w_word_last;
  logic                     w_cmd_clear;
  logic [W-1:0]             w_tx_next;
  logic                     w_clr_next;
  logic                     w_busy;
  logic                     w_done;
  logic                     w_in_ready;
  logic                     w_rd_valid;
  logic [W-1:0]             w_rd_data;
  logic                     w_sclk;
  logic                     w_sdi;
  logic                     w_latch;
  logic                     w_rst_n;

  assign w_run       = (r_state == ST_SETUP) || (r_state == ST_HIGH) ||
                       (r_state == ST_LATCH_WAIT) || (r_state == ST_LATCH_HI);
  assign w_hs        = (r_state == ST_FETCH) && i_in_valid;
  assign w_setup_end = (r_state == ST_SETUP) && w_phase_end;
  assign w_high_end  = (r_state == ST_HIGH) && w_phase_end;
  assign w_bit_last  = (r_bitcnt == C_BITCNT_W'(W - 1));
  assign w_word_last = (r_wordcnt == C_WORDCNT_W'(C_NW - 1));
  assign w_cmd_clear = (r_state == ST_IDLE) && i_clear && !i_start;

  cfgsr_clkgen #(
    .DIV (DIV)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .i_run       (w_run),
    .o_phase_end (w_phase_end)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decode; start has priority over clear in IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start)      w_next = ST_FETCH;
        else if (i_clear) w_next = ST_SETUP;
      end
      ST_FETCH: begin
        if (i_in_valid) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (w_phase_end) w_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          if (r_clr)            w_next = ST_LATCH_WAIT;
          else if (!w_bit_last) w_next = ST_SETUP;
          else if (w_word_last) w_next = ST_LATCH_WAIT;
          else                  w_next = ST_FETCH;
        end
      end
      ST_LATCH_WAIT: begin
        if (w_phase_end) w_next = ST_LATCH_HI;
      end
      ST_LATCH_HI: begin
        if (w_phase_end) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Next values of the tx shifter and the clear-sequence flag.
  always_comb begin
    w_tx_next = r_tx;
    if (w_hs) begin
      w_tx_next = i_in_data;
    end else if (w_high_end) begin
      w_tx_next = {r_tx[W-2:0], 1'b0};
    end else if (w_cmd_clear) begin
      w_tx_next = '0;
    end
    w_clr_next = (r_state == ST_IDLE) ? w_cmd_clear : r_clr;
  end

  // Output decode from the next state so registered outputs line up with it.
  always_comb begin
    w_busy     = (w_next != ST_IDLE) && (w_next != ST_DONE);
    w_done     = (w_next == ST_DONE);
    w_in_ready = (w_next == ST_FETCH);
    w_sclk     = (w_next == ST_HIGH);
    w_latch    = (w_next == ST_LATCH_HI);
    w_rst_n    = !(w_clr_next && ((w_next == ST_SETUP) || (w_next == ST_HIGH)));
    w_sdi      = w_tx_next[W-1];
    w_rd_valid = w_high_end && w_bit_last && !r_clr;
    w_rd_data  = w_rd_valid ? r_rx : o_rd_data;
  end

  // Output registers: no combinational path from inputs to any port.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_in_ready  <= 1'b0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_cfg_sclk  <= 1'b0;
      o_cfg_sdi   <= 1'b0;
      o_cfg_latch <= 1'b0;
      o_cfg_rst_n <= 1'b1;
    end else begin
      o_busy      <= w_busy;
      o_done      <= w_done;
      o_in_ready  <= w_in_ready;
      o_rd_valid  <= w_rd_valid;
      o_rd_data   <= w_rd_data;
      o_cfg_sclk  <= w_sclk;
      o_cfg_sdi   <= w_sdi;
      o_cfg_latch <= w_latch;
      o_cfg_rst_n <= w_rst_n;
    end
  end

  // Datapath: shifters and counters. sdo is captured on the last SETUP cycle,
  // i.e. before the sclk rising edge, so it reads the old chain bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bitcnt  <= '0;
      r_wordcnt <= '0;
      r_clr     <= 1'b0;
    end else begin
      r_tx  <= w_tx_next;
      r_clr <= w_clr_next;
      if (w_setup_end) begin
        r_rx <= {r_rx[W-2:0], i_cfg_sdo};
      end
      if (r_state == ST_IDLE) begin
        r_bitcnt  <= '0;
        r_wordcnt <= '0;
      end else if (w_high_end && !r_clr) begin
        r_bitcnt <= w_bit_last ? '0 : (r_bitcnt + C_BITCNT_W'(1));
        if (w_bit_last) begin
          r_wordcnt <= w_word_last ? '0 : (r_wordcnt + C_WORDCNT_W'(1));
        end
      end
    end
  end

endmodule : cfgsr_ctrl
`default_nettype wire

// File: tb/tb_cfgsr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfgsr_ctrl
//  Purpose  : Self-checking bench for cfgsr_ctrl with a behavioural model of
//             the serial config chain and a readback scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfgsr_ctrl;

  localparam int N     = 64;
  localparam int W     = 16;
  localparam int DIV   = 2;
  localparam int NW    = N / W;
  localparam int BOUND = 3000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_clear = 1'b0;
  logic         i_in_valid = 1'b0;
  logic [W-1:0] i_in_data = '0;
  logic         o_in_ready;
  logic         o_rd_valid;
  logic [W-1:0] o_rd_data;
  logic         o_busy;
  logic         o_done;
  logic         o_cfg_sclk;
  logic         o_cfg_sdi;
  logic         o_cfg_latch;
  logic         o_cfg_rst_n;
  logic         w_cfg_sdo;

  always #5 clk = ~clk;

  cfgsr_ctrl #(.N(N), .W(W), .DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_clear     (i_clear),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_cfg_sclk  (o_cfg_sclk),
    .o_cfg_sdi   (o_cfg_sdi),
    .o_cfg_latch (o_cfg_latch),
    .o_cfg_rst_n (o_cfg_rst_n),
    .i_cfg_sdo   (w_cfg_sdo)
  );

  // Behavioural chain: shift on sclk rise (sync reset when rst_n low), latch on rise.
  logic [N-1:0] sr = '0;
  logic [N-1:0] dq = '0;
  int           rise_cnt = 0;
  int           low_edges = 0;
  assign w_cfg_sdo = sr[N-1];

  always @(posedge o_cfg_sclk) begin
    rise_cnt <= rise_cnt + 1;
    if (!o_cfg_rst_n) begin
      sr        <= '0;
      low_edges <= low_edges + 1;
    end else begin
      sr <= {sr[N-2:0], o_cfg_sdi};
    end
  end

  always @(posedge o_cfg_latch) dq <= sr;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] sb_e;
  logic [N-1:0] exp_chain = '0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Readback scoreboard: every rd_valid pops one expected word.
  always @(negedge clk) begin
    if (o_rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rd_data %0h expected no rd_valid at %0t", o_rd_data, $time);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rd_data", {{(N-W){1'b0}}, o_rd_data}, {{(N-W){1'b0}}, sb_e});
      end
    end
  end

  typedef struct {
    logic [N-1:0] data;
    int           stall_word;
    int           stall_cyc;
    bit           with_clear;
    int           poke_cyc;
    int           exp_lat;
  } vec_t;

  vec_t tbl[5];

  task automatic drive_words(input logic [N-1:0] d, input int sw, input int sc);
    int           t;
    logic [N-1:0] snap;
    for (int k = 0; k < NW; k++) begin
      if (k == sw) begin
        i_in_valid = 1'b0;
        t = 0;
        while (o_in_ready !== 1'b1 && t < BOUND) begin
          @(negedge clk);
          t++;
        end
        snap = sr;
        for (int i = 0; i < sc; i++) begin
          @(posedge clk);
          #1;
          chk("stall_sclk", {63'd0, o_cfg_sclk}, 64'd0);
          chk("stall_ready", {63'd0, o_in_ready}, 64'd1);
        end
        chk("stall_sr", sr, snap);
      end
      i_in_valid = 1'b1;
      i_in_data  = d[N-1-k*W -: W];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (o_in_ready !== 1'b1 && t < BOUND);
      if (t >= BOUND) begin
        chk("fetch_timeout", 64'(t), 64'(BOUND - 1));
        i_in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic run_prog(input vec_t v);
    int cnt;
    bit got;
    int low0;
    low0 = low_edges;
    for (int k = 0; k < NW; k++) sb_q.push_back(exp_chain[N-1-k*W -: W]);
    exp_chain = v.data;
    i_start = 1'b1;
    i_clear = v.with_clear;
    cnt = 0;
    got = 1'b0;
    fork
      begin
        while (!got && cnt < BOUND) begin
          @(posedge clk);
          cnt++;
          #1;
          i_start = 1'b0;
          i_clear = 1'b0;
          if (v.poke_cyc != 0 && cnt == v.poke_cyc) begin
            chk("busy_mid", {63'd0, o_busy}, 64'd1);
            i_start = 1'b1;
            i_clear = 1'b1;
          end
          if (o_done === 1'b1) got = 1'b1;
        end
      end
      drive_words(v.data, v.stall_word, v.stall_cyc);
    join
    chk("done_seen", {63'd0, got}, 64'd1);
    chk("latency", 64'(cnt), 64'(v.exp_lat));
    chk("busy_at_done", {63'd0, o_busy}, 64'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", {63'd0, o_done}, 64'd0);
    chk("dq", dq, v.data);
    chk("no_chain_reset", 64'(low_edges - low0), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    int rise0;
    int low0;
    logic [N-1:0] dq0;

    tbl[0] = '{64'hA5A5_0F0F_FFFF_1234, -1, 0,  1'b0, 0,   N*2*DIV + NW + 2*DIV + 1};
    tbl[1] = '{64'h0000_0000_0000_0000, -1, 0,  1'b0, 0,   N*2*DIV + NW + 2*DIV + 1};
    tbl[2] = '{64'hDEAD_BEEF_CAFE_F00D,  2, 10, 1'b0, 0,   N*2*DIV + NW + 2*DIV + 1 + 10};
    tbl[3] = '{64'h0123_4567_89AB_CDEF, -1, 0,  1'b1, 100, N*2*DIV + NW + 2*DIV + 1};
    tbl[4] = '{64'h1357_9BDF_2468_ACE0, -1, 0,  1'b0, 0,   N*2*DIV + NW + 2*DIV + 1};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     {63'd0, o_busy},      64'd0);
    chk("rst_done",     {63'd0, o_done},      64'd0);
    chk("rst_in_ready", {63'd0, o_in_ready},  64'd0);
    chk("rst_rd_valid", {63'd0, o_rd_valid},  64'd0);
    chk("rst_rd_data",  {48'd0, o_rd_data},   64'd0);
    chk("rst_sclk",     {63'd0, o_cfg_sclk},  64'd0);
    chk("rst_sdi",      {63'd0, o_cfg_sdi},   64'd0);
    chk("rst_latch",    {63'd0, o_cfg_latch}, 64'd0);
    chk("rst_rst_n",    {63'd0, o_cfg_rst_n}, 64'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run_prog(tbl[i]);
      repeat (3) @(posedge clk);
      #1;
    end

    // Clear sequence: one sclk rise with rst_n low, chain and latch end at zero.
    low0  = low_edges;
    rise0 = rise_cnt;
    exp_chain = '0;
    i_clear = 1'b1;
    cnt = 0;
    while (cnt < BOUND) begin
      @(posedge clk);
      cnt++;
      #1;
      i_clear = 1'b0;
      if (cnt == 1) chk("clear_ready", {63'd0, o_in_ready}, 64'd0);
      if (o_done === 1'b1) break;
    end
    chk("clear_latency", 64'(cnt), 64'(4*DIV + 1));
    chk("clear_low_edges", 64'(low_edges - low0), 64'd1);
    chk("clear_rises", 64'(rise_cnt - rise0), 64'd1);
    chk("clear_sr", sr, 64'd0);
    chk("clear_dq", dq, 64'd0);
    chk("clear_rst_n_back", {63'd0, o_cfg_rst_n}, 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Reset after 7 bits of a program: chain aborted, no latch.
    dq0   = dq;
    rise0 = rise_cnt;
    i_in_valid = 1'b1;
    i_in_data  = 16'hFFFF;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    cnt = 0;
    while ((rise_cnt - rise0) < 7 && cnt < BOUND) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("pre_rst_rises", 64'(rise_cnt - rise0), 64'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_in_valid = 1'b0;
    chk("abort_sclk",  {63'd0, o_cfg_sclk},  64'd0);
    chk("abort_latch", {63'd0, o_cfg_latch}, 64'd0);
    chk("abort_busy",  {63'd0, o_busy},      64'd0);
    chk("abort_rst_n", {63'd0, o_cfg_rst_n}, 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_rises", 64'(rise_cnt - rise0), 64'd7);
    chk("abort_dq", dq, dq0);
    chk("abort_idle_busy", {63'd0, o_busy}, 64'd0);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cfgsr_ctrl
`default_nettype wire
